// File: rtl/muldiv_seq.sv
// Iterative 32-step multiply/divide sequencer for the EXE stage.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module muldiv_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sgn1_q, sgn1_d;
  logic        sgn2_q, sgn2_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        is_div;
  logic [31:0] mag1, mag2;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] prod_neg;

  assign is_div   = op_q[1];
  assign mag1     = sgn1_q ? (~src1_q + 32'd1) : src1_q;
  assign mag2     = sgn2_q ? (~src2_q + 32'd1) : src2_q;
  assign mul_sum  = {1'b0, acc_q[63:32]}
                  + {1'b0, (b_q[0] ? a_q : 32'd0)};
  // Remainder lives in acc[63:32]; dividend bits shift out of b_q
  assign rem_sh   = {acc_q[63:32], b_q[31]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, a_q};
  assign prod_neg = ~acc_q + 64'd1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sgn1_d  = sgn1_q;
    sgn2_d  = sgn2_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_d = S_PREP;
            op_d    = req_op;
            sgn1_d  = ~req_op[0] & req_src1[31];
            sgn2_d  = ~req_op[0] & req_src2[31];
            src1_d  = req_src1;
            src2_d  = req_src2;
            dbz_d   = 1'b0;
          end
        end
        S_PREP: begin
          a_d     = is_div ? mag2 : mag1;
          b_d     = is_div ? mag1 : mag2;
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (is_div) begin
            acc_d[63:32] = div_diff[33] ? rem_sh[31:0]
                                        : div_diff[31:0];
            b_d = {b_q[30:0], ~div_diff[33]};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
            b_d   = {1'b0, b_q[31:1]};
          end
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          if (!is_div) begin
            {hi_d, lo_d} = (sgn1_q ^ sgn2_q) ? prod_neg : acc_q;
          end else if (src2_q == 32'd0) begin
            hi_d  = src1_q;
            lo_d  = 32'hFFFF_FFFF;
            dbz_d = 1'b1;
          end else begin
            lo_d = (sgn1_q ^ sgn2_q) ? (~b_q + 32'd1) : b_q;
            hi_d = sgn1_q ? (~acc_q[63:32] + 32'd1)
                          : acc_q[63:32];
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule
